// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps at most one IMEM request in flight,
// and drives the IF/ID register, with a one-entry skid for stalls and flush on EX redirect.
module fetch_stage #(
    parameter int unsigned                REG_DATA_WIDTH = 32,
    parameter logic [REG_DATA_WIDTH-1:0]  PC_RESET       = 32'h0000_0000,
    parameter logic [REG_DATA_WIDTH-1:0]  NOP_INSTR      = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      Pipe_stall,
    input  logic                      EX_Branch_taken,
    input  logic [REG_DATA_WIDTH-1:0] EX_Branch_target,
    output logic                      IMEM_req,
    output logic [REG_DATA_WIDTH-1:0] IMEM_addr,
    input  logic                      IMEM_rvalid,
    input  logic [REG_DATA_WIDTH-1:0] IMEM_rdata,
    output logic                      ID_Valid,
    output logic [REG_DATA_WIDTH-1:0] ID_PC,
    output logic [REG_DATA_WIDTH-1:0] ID_PC_plus4,
    output logic [REG_DATA_WIDTH-1:0] ID_Instruction
);

    localparam logic [REG_DATA_WIDTH-1:0] PC_INC     = REG_DATA_WIDTH'(3'd4);
    localparam logic [REG_DATA_WIDTH-1:0] ALIGN_MASK = ~(REG_DATA_WIDTH'(2'b11));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e                    state_q;
    logic [REG_DATA_WIDTH-1:0] pc_q;
    logic [REG_DATA_WIDTH-1:0] fetch_pc_q;
    logic [REG_DATA_WIDTH-1:0] skid_pc_q;
    logic [REG_DATA_WIDTH-1:0] skid_instr_q;
    logic                      drop_q;
    logic                      id_valid_q;
    logic [REG_DATA_WIDTH-1:0] id_pc_q;
    logic [REG_DATA_WIDTH-1:0] id_pc4_q;
    logic [REG_DATA_WIDTH-1:0] id_instr_q;
    logic                      req_s;

    // Request decode: a new fetch goes out whenever the stage has nothing in flight or held.
    always_comb begin
        req_s = 1'b0;
        if (!rst_n || EX_Branch_taken) begin
            req_s = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  req_s = 1'b1;
                S_WAIT:  req_s = IMEM_rvalid && !drop_q && !Pipe_stall;
                S_HOLD:  req_s = !Pipe_stall;
                default: req_s = 1'b0;
            endcase
        end
    end

    assign IMEM_req       = req_s;
    assign IMEM_addr      = pc_q;
    assign ID_Valid       = id_valid_q;
    assign ID_PC          = id_pc_q;
    assign ID_PC_plus4    = id_pc4_q;
    assign ID_Instruction = id_instr_q;

    // Fetch FSM, PC, skid and IF/ID register; a redirect overrides every other update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= PC_RESET;
            fetch_pc_q   <= PC_RESET;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            drop_q       <= 1'b0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_pc4_q     <= PC_INC;
            id_instr_q   <= NOP_INSTR;
        end else if (EX_Branch_taken) begin
            pc_q       <= EX_Branch_target & ALIGN_MASK;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            // A response still on its way must be swallowed before fetching the new path.
            if (state_q == S_WAIT && !IMEM_rvalid) begin
                drop_q  <= 1'b1;
                state_q <= S_WAIT;
            end else begin
                drop_q  <= 1'b0;
                state_q <= S_IDLE;
            end
        end else begin
            if (req_s) begin
                fetch_pc_q <= pc_q;
                pc_q       <= pc_q + PC_INC;
            end
            case (state_q)
                S_IDLE: begin
                    state_q <= S_WAIT;
                    if (!Pipe_stall) begin
                        id_valid_q <= 1'b0;
                        id_instr_q <= NOP_INSTR;
                    end
                end
                S_WAIT: begin
                    if (IMEM_rvalid && drop_q) begin
                        drop_q  <= 1'b0;
                        state_q <= S_IDLE;
                        if (!Pipe_stall) begin
                            id_valid_q <= 1'b0;
                            id_instr_q <= NOP_INSTR;
                        end
                    end else if (IMEM_rvalid && Pipe_stall) begin
                        skid_pc_q    <= fetch_pc_q;
                        skid_instr_q <= IMEM_rdata;
                        state_q      <= S_HOLD;
                    end else if (IMEM_rvalid) begin
                        id_valid_q <= 1'b1;
                        id_pc_q    <= fetch_pc_q;
                        id_pc4_q   <= fetch_pc_q + PC_INC;
                        id_instr_q <= IMEM_rdata;
                    end else if (!Pipe_stall) begin
                        id_valid_q <= 1'b0;
                        id_instr_q <= NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!Pipe_stall) begin
                        id_valid_q <= 1'b1;
                        id_pc_q    <= skid_pc_q;
                        id_pc4_q   <= skid_pc_q + PC_INC;
                        id_instr_q <= skid_instr_q;
                        state_q    <= S_WAIT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-configurable instruction memory plus a stream-level
// reference model of what IF/ID must show and when a fetch may be issued.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Pipe_stall, EX_Branch_taken, IMEM_rvalid;
    logic [31:0] EX_Branch_target, IMEM_rdata;
    logic        IMEM_req, ID_Valid;
    logic [31:0] IMEM_addr, ID_PC, ID_PC_plus4, ID_Instruction;

    logic        u2_stall, u2_br, u2_rvalid, u2_req, u2_valid;
    logic [31:0] u2_tgt, u2_rdata, u2_addr, u2_pc, u2_pc4, u2_instr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .Pipe_stall(Pipe_stall),
        .EX_Branch_taken(EX_Branch_taken), .EX_Branch_target(EX_Branch_target),
        .IMEM_req(IMEM_req), .IMEM_addr(IMEM_addr),
        .IMEM_rvalid(IMEM_rvalid), .IMEM_rdata(IMEM_rdata),
        .ID_Valid(ID_Valid), .ID_PC(ID_PC), .ID_PC_plus4(ID_PC_plus4),
        .ID_Instruction(ID_Instruction)
    );

    fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .Pipe_stall(u2_stall),
        .EX_Branch_taken(u2_br), .EX_Branch_target(u2_tgt),
        .IMEM_req(u2_req), .IMEM_addr(u2_addr),
        .IMEM_rvalid(u2_rvalid), .IMEM_rdata(u2_rdata),
        .ID_Valid(u2_valid), .ID_PC(u2_pc), .ID_PC_plus4(u2_pc4),
        .ID_Instruction(u2_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F2E} + 32'h0001_0101;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // memory and model state
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          mq_due[$];
    logic [31:0] mq_addr[$];
    logic [31:0] m_out_pc[$];
    bit          m_out_fl[$];
    logic [31:0] m_fetch, m_skid_pc, e_pc, e_instr;
    bit          m_skid_v, e_v, e_pc_known;
    int          req_cyc[$];
    logic [31:0] req_adr[$];
    int          dlv_cyc[$];
    logic [31:0] dlv_pc[$];

    // Compare + memory bookkeeping, once per cycle at the falling edge.
    always @(negedge clk) begin : compare
        bit got, drained, fl, exp_req;
        logic [31:0] rpc;
        if (rst_n !== 1'b1) begin
            mq_due.delete(); mq_addr.delete(); m_out_pc.delete(); m_out_fl.delete();
            m_fetch = 32'h0; m_skid_v = 1'b0;
            e_v = 1'b0; e_pc = 32'h0; e_instr = NOP; e_pc_known = 1'b1;
        end else begin
            chk("id_valid", ID_Valid, e_v);
            chk("id_instr", ID_Instruction, e_instr);
            if (e_pc_known) begin
                chk("id_pc", ID_PC, e_pc);
                chk("id_pc_plus4", ID_PC_plus4, e_pc + 32'd4);
            end
            got = 1'b0; drained = 1'b0; fl = 1'b0; rpc = 32'h0;
            if (IMEM_rvalid && m_out_pc.size() > 0) begin
                rpc = m_out_pc.pop_front();
                fl  = m_out_fl.pop_front();
                void'(mq_due.pop_front());
                void'(mq_addr.pop_front());
                if (fl) drained = 1'b1;
                else    got = 1'b1;
            end
            if (EX_Branch_taken) begin
                for (int i = 0; i < m_out_fl.size(); i++) m_out_fl[i] = 1'b1;
                m_skid_v = 1'b0;
                e_v = 1'b0; e_instr = NOP; e_pc_known = 1'b0;
                m_fetch = EX_Branch_target & 32'hFFFF_FFFC;
                exp_req = 1'b0;
            end else begin
                if (!Pipe_stall && (m_skid_v || got)) begin
                    e_pc = m_skid_v ? m_skid_pc : rpc;
                    e_v = 1'b1; e_instr = mem_word(e_pc); e_pc_known = 1'b1;
                    dlv_cyc.push_back(cyc + 1); dlv_pc.push_back(e_pc);
                    m_skid_v = 1'b0;
                end else if (!Pipe_stall) begin
                    e_v = 1'b0; e_instr = NOP; e_pc_known = 1'b0;
                end else if (got) begin
                    m_skid_v = 1'b1; m_skid_pc = rpc;
                end
                exp_req = (m_out_pc.size() == 0) && !m_skid_v && !drained;
            end
            chk("imem_req", IMEM_req, exp_req);
            if (IMEM_req) begin
                if (!EX_Branch_taken) chk("imem_addr", IMEM_addr, m_fetch);
                req_cyc.push_back(cyc); req_adr.push_back(IMEM_addr);
                m_out_pc.push_back(m_fetch); m_out_fl.push_back(EX_Branch_taken);
                mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                mq_addr.push_back(IMEM_addr);
                if (!EX_Branch_taken) m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
    end

    task automatic drive(input bit st, input bit br, input logic [31:0] tg);
        @(posedge clk); #1;
        Pipe_stall = st; EX_Branch_taken = br; EX_Branch_target = tg;
        if (rst_n === 1'b1 && mq_due.size() > 0 && mq_due[0] <= cyc) begin
            IMEM_rvalid = 1'b1; IMEM_rdata = mem_word(mq_addr[0]);
        end else begin
            IMEM_rvalid = 1'b0; IMEM_rdata = $urandom;
        end
    endtask

    task automatic clear_logs();
        req_cyc.delete(); req_adr.delete(); dlv_cyc.delete(); dlv_pc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, IMEM_req, 1'b0);
        chk({tag, "_addr"}, IMEM_addr, 32'h0);
        chk({tag, "_valid"}, ID_Valid, 1'b0);
        chk({tag, "_pc"}, ID_PC, 32'h0);
        chk({tag, "_pc4"}, ID_PC_plus4, 32'h4);
        chk({tag, "_instr"}, ID_Instruction, NOP);
    endtask

    // first request / first delivery strictly after a given cycle
    function automatic int first_req_after(input int c);
        for (int i = 0; i < req_cyc.size(); i++) if (req_cyc[i] > c) return i;
        return -1;
    endfunction
    function automatic int first_dlv_after(input int c);
        for (int i = 0; i < dlv_cyc.size(); i++) if (dlv_cyc[i] > c) return i;
        return -1;
    endfunction

    // Wrap-around instance: single-cycle memory, no stalls or redirects.
    initial begin : wrap_test
        u2_stall = 1'b0; u2_br = 1'b0; u2_tgt = 32'h0; u2_rvalid = 1'b0; u2_rdata = 32'h0;
        wait (rst_n === 1'b1);
        @(negedge clk);
        chk("wrap_req0", u2_req, 1'b1);
        chk("wrap_addr0", u2_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        u2_rvalid = 1'b1; u2_rdata = 32'hA1A1_0001;
        @(negedge clk);
        chk("wrap_req1", u2_req, 1'b1);
        chk("wrap_addr1", u2_addr, 32'h0000_0000);
        @(posedge clk); #1;
        chk("wrap_id_valid", u2_valid, 1'b1);
        chk("wrap_id_pc", u2_pc, 32'hFFFF_FFFC);
        chk("wrap_id_pc4", u2_pc4, 32'h0000_0000);
        chk("wrap_id_instr", u2_instr, 32'hA1A1_0001);
        u2_rvalid = 1'b1; u2_rdata = 32'hA2A2_0002;
        @(posedge clk); #1;
        chk("wrap_id_pc_next", u2_pc, 32'h0000_0000);
        chk("wrap_id_instr_next", u2_instr, 32'hA2A2_0002);
        u2_rvalid = 1'b0;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int s, bc, idx, nreq, i0;
        bit found;
        rst_n = 1'b0;
        Pipe_stall = 1'b0; EX_Branch_taken = 1'b0; EX_Branch_target = 32'h0;
        IMEM_rvalid = 1'b0; IMEM_rdata = 32'h0;

        // reset, then single-cycle memory with no stalls
        repeat (3) drive(1'b0, 1'b0, 32'h0);
        check_reset_outputs("rst");
        drive(1'b0, 1'b0, 32'h0);
        clear_logs();
        rst_n = 1'b1;
        repeat (7) drive(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("seq_addr", req_adr[k], 32'(4 * k));
            chk("seq_req_cycle", req_cyc[k] - req_cyc[0], k);
            chk("seq_dlv_pc", dlv_pc[k], 32'(4 * k));
            chk("seq_dlv_cycle", dlv_cyc[k] - req_cyc[k], 2);
        end

        // three-cycle stall while a response lands in the skid
        drive(1'b1, 1'b0, 32'h0);
        s = cyc;
        drive(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        repeat (4) drive(1'b0, 1'b0, 32'h0);
        nreq = 0;
        for (int i = 0; i < req_cyc.size(); i++) if (req_cyc[i] >= s && req_cyc[i] <= s + 2) nreq++;
        chk("stall_no_req", nreq, 0);
        idx = first_dlv_after(s);
        i0 = first_dlv_after(s - 1);
        if (idx < 0 || i0 < 0) chk("stall_skid_found", 0, 1);
        else begin
            chk("stall_skid_cycle", dlv_cyc[idx], s + 4);
            chk("stall_skid_pc", dlv_pc[idx], dlv_pc[i0] + 32'd4);
        end

        // reset mid-WAIT with three-cycle memory, then redirect to 0x100 during fetch of 0x8
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            if (req_cyc.size() > 0 && req_cyc[$] == cyc - 1) found = 1'b1;
        end
        chk("midwait_reached", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        clear_logs();
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            drive(1'b0, 1'b0, 32'h0);
            if (req_adr.size() > 0 && req_adr[$] == 32'h8 && req_cyc[$] == cyc - 1) found = 1'b1;
        end
        chk("restart_first_addr", req_adr.size() > 0 ? req_adr[0] : 32'hDEAD_BEEF, 32'h0);
        chk("fetch8_reached", found, 1'b1);
        EX_Branch_taken = 1'b1; EX_Branch_target = 32'h0000_0100;
        bc = cyc;
        drive(1'b0, 1'b0, 32'h0);
        chk("redir_valid", ID_Valid, 1'b0);
        chk("redir_instr", ID_Instruction, NOP);
        repeat (10) drive(1'b0, 1'b0, 32'h0);
        idx = first_req_after(bc);
        if (idx < 0) chk("redir_req_found", 0, 1);
        else begin
            chk("redir_addr", req_adr[idx], 32'h0000_0100);
            chk("redir_req_cycle", req_cyc[idx], bc + 3);
        end
        idx = first_dlv_after(bc);
        if (idx < 0) chk("redir_dlv_found", 0, 1);
        else begin
            chk("redir_dlv_pc", dlv_pc[idx], 32'h0000_0100);
            chk("redir_dlv_cycle", dlv_cyc[idx], bc + 7);
        end

        // redirect to a misaligned target while stalled with the skid full
        lat_min = 1; lat_max = 1;
        repeat (8) drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        s = cyc;
        drive(1'b1, 1'b1, 32'h0000_0203);
        drive(1'b0, 1'b0, 32'h0);
        chk("flush_wins_valid", ID_Valid, 1'b0);
        repeat (6) drive(1'b0, 1'b0, 32'h0);
        idx = first_req_after(s);
        if (idx < 0) chk("misalign_req_found", 0, 1);
        else begin
            chk("misalign_addr", req_adr[idx], 32'h0000_0200);
            chk("misalign_req_cycle", req_cyc[idx], s + 2);
        end
        idx = first_dlv_after(s);
        if (idx < 0) chk("skid_flushed_found", 0, 1);
        else begin
            chk("skid_flushed_pc", dlv_pc[idx], 32'h0000_0200);
            chk("skid_flushed_cycle", dlv_cyc[idx], s + 4);
        end

        // randomized traffic: variable latency, stalls, redirects (some near the wrap point)
        lat_min = 1; lat_max = 4;
        clear_logs();
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] tg;
            tg = $urandom;
            if ($urandom_range(9) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'h0000_000F);
            drive($urandom_range(99) < 25, $urandom_range(99) < 5, tg);
            if (k % 50 == 49) begin
                chk("progress", req_cyc.size() > nreq, 1'b1);
                nreq = req_cyc.size();
            end
        end
        drive(1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
